serial_compare: RTL and testbench
=================================

Name: serial_compare

Overview:
- Parametrised, multi-cycle magnitude comparator that generalises the 4-bit combinational compare block.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, with start/busy/done handshake, selectable signed/unsigned mode and optional early exit on first differing chunk.
- Sits beside datapath blocks that need wide compares without a long combinational carry chain; results are held until the next accepted start.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK
CHUNK, 4, bits compared per clock; 1 <= CHUNK <= WIDTH
EARLY_EXIT, 1, 1 = finish on first unequal chunk; 0 = always scan all NCHUNK = WIDTH/CHUNK chunks (fixed latency)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted on a clk edge only while busy=0
signed_mode  input  1  1 = two's-complement compare; sampled with start
in1  input  WIDTH  operand A; sampled with start
in2  input  WIDTH  operand B; sampled with start
busy  output  1  high from accept edge until the result edge
done  output  1  one-cycle pulse, result valid
g  output  1  in1 > in2
e  output  1  in1 == in2
l  output  1  in1 < in2
chunks  output  clog2(NCHUNK+1)  number of chunks examined for the held result

Behaviour:
- Reset (async, immediate, also mid-operation): state IDLE; busy, done, g, e, l = 0; chunks = 0; shift registers cleared.
- States: IDLE, RUN. Done is a registered pulse, not a state.
- IDLE, start=1 at edge E0: load operand shift registers with in1/in2. When signed_mode=1, invert bit WIDTH-1 of both operands at load (offset-binary), so unsigned chunk compare gives the signed order. Clear g/e/l/chunks, set busy=1, go to RUN.
- RUN cycle i (between edges Ei and Ei+1): compare the top CHUNK bits of both registers, unsigned.
  - Chunks differ and EARLY_EXIT=1: at Ei+1 set g or l, chunks = i+1, busy=0, done=1, go to IDLE.
  - Chunks differ and EARLY_EXIT=0: latch the first-difference verdict internally and keep scanning. Later chunks never override it.
  - Chunks equal: shift both registers left by CHUNK and increment the index.
  - After chunk NCHUNK-1 with no difference: e=1, chunks = NCHUNK.
- Latency from accept edge to result edge: k edges, where k = index of first differing chunk + 1 (or NCHUNK). With EARLY_EXIT=0, k is always NCHUNK. done is high in the cycle after the result edge.
- Exactly one of g/e/l is high from the result edge until the next accepted start. All three are 0 while busy.
- start while busy=1: ignored; operands not resampled.
- start in the cycle done=1: legal. State is IDLE, so it is accepted at the next edge and g/e/l clear on that edge.
- in1, in2 and signed_mode may change freely after the accept edge.
- CHUNK = WIDTH: single-cycle compare, result one edge after accept.
- Chunk index counter width clog2(NCHUNK); no wrap because the scan terminates at NCHUNK-1.

Decomposition:
- Package serial_compare_pkg: state enum (IDLE, RUN) and a function nchunk(WIDTH, CHUNK).
- Elaboration check that WIDTH % CHUNK == 0.
- One sub-module, chunk_compare: purely combinational CHUNK-bit unsigned comparator with outputs gt and eq, instantiated once on the register MSB slices.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
1. Reset, then in1=in2=0x1234, unsigned, start -> busy for 4 edges, done pulse, e=1, g=l=0, chunks=4.
2. in1=0x8000, in2=0x7FFF, unsigned -> g=1, chunks=1, done one edge after accept. Same operands with signed_mode=1 -> l=1, chunks=1. in1=in2=0xFFFF signed -> e=1.
3. in1=0x0100, in2=0x0200 -> l=1, chunks=2. in1=0x1235, in2=0x1234 -> g=1, chunks=4.
4. Start 0x0001 vs 0x0002. Pulse start again at edge 2 with 0xFFFF vs 0x0000 -> second start ignored; result l=1, chunks=4, single done pulse.
5. Assert rst_n=0 mid-scan at cycle 2 -> busy/done/g/e/l/chunks are 0 immediately, without waiting for a clk edge. After release, a new start 0x0005 vs 0x0005 gives e=1.
6. EARLY_EXIT=0 instance, 0x8000 vs 0x7FFF -> done only after 4 edges, g=1, chunks=4. CHUNK=16 instance -> result one edge after accept, chunks=1.

Source files
------------

// File: rtl/serial_compare_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_compare_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/serial_compare_if.sv
// Request/result bundle between a datapath master and the serial comparator.
interface serial_compare_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  import serial_compare_pkg::*;

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = $clog2(NCHUNK + 1);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic             g;
  logic             e;
  logic             l;
  logic [CW-1:0]    chunks;

  modport master (
    output start, signed_mode, in1, in2,
    input  busy, done, g, e, l, chunks
  );

  modport slave (
    input  start, signed_mode, in1, in2,
    output busy, done, g, e, l, chunks
  );

endinterface

// File: rtl/serial_compare_chunk_compare.sv
// Combinational unsigned compare of one chunk slice.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq
);

  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_compare.sv
// Multi-cycle MSB-first magnitude comparator: scans CHUNK bits per clock and
// holds a one-hot g/e/l verdict until the next accepted start.
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_compare_if.slave bus
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] SIGNBIT = WIDTH'(1) << (WIDTH - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("serial_compare: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [IW-1:0]    idx;
  logic             found;
  logic             found_gt;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             last;

  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a  (ra[WIDTH-1 -: CHUNK]),
    .b  (rb[WIDTH-1 -: CHUNK]),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  assign last = (idx == IW'(NCHUNK - 1));

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the chunk comparator never needs to know about signedness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ra         <= '0;
      rb         <= '0;
      idx        <= '0;
      found      <= 1'b0;
      found_gt   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.g      <= 1'b0;
      bus.e      <= 1'b0;
      bus.l      <= 1'b0;
      bus.chunks <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra         <= bus.in1 ^ (bus.signed_mode ? SIGNBIT : '0);
            rb         <= bus.in2 ^ (bus.signed_mode ? SIGNBIT : '0);
            idx        <= '0;
            found      <= 1'b0;
            found_gt   <= 1'b0;
            bus.g      <= 1'b0;
            bus.e      <= 1'b0;
            bus.l      <= 1'b0;
            bus.chunks <= '0;
            bus.busy   <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (!cmp_eq && EARLY_EXIT != 0) begin
            bus.g      <= cmp_gt;
            bus.l      <= !cmp_gt;
            bus.chunks <= CW'(idx) + CW'(1);
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= IDLE;
          end else begin
            // Only the first differing chunk decides; later ones are ignored.
            if (!cmp_eq && !found) begin
              found    <= 1'b1;
              found_gt <= cmp_gt;
            end
            if (last) begin
              if (found) begin
                bus.g <= found_gt;
                bus.l <= !found_gt;
              end else if (!cmp_eq) begin
                bus.g <= cmp_gt;
                bus.l <= !cmp_gt;
              end else begin
                bus.e <= 1'b1;
              end
              bus.chunks <= CW'(NCHUNK);
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state      <= IDLE;
            end else begin
              ra  <= ra << CHUNK;
              rb  <= rb << CHUNK;
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare.sv
// Directed bench: one table of compares run on three comparator variants,
// plus hand-written sequences for busy-start, async reset and held results.
module tb_serial_compare;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  gel;
    int          chunksA;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  serial_compare_if #(.WIDTH(16), .CHUNK(4))  busA ();
  serial_compare_if #(.WIDTH(16), .CHUNK(4))  busB ();
  serial_compare_if #(.WIDTH(16), .CHUNK(16)) busC ();

  serial_compare #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dutA (
    .clk (clk), .rst_n (rst_n), .bus (busA)
  );
  serial_compare #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dutB (
    .clk (clk), .rst_n (rst_n), .bus (busB)
  );
  serial_compare #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1)) dutC (
    .clk (clk), .rst_n (rst_n), .bus (busC)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Start the same compare on all three variants and follow each to its result.
  task automatic applyStimulus(input int id, input logic sm, input logic [15:0] a,
                               input logic [15:0] b, input logic [2:0] gel,
                               input int chunksA);
    int nA = 0;
    int nB = 0;
    int nC = 0;
    @(negedge clk);
    busA.start = 1'b1; busA.signed_mode = sm; busA.in1 = a; busA.in2 = b;
    busB.start = 1'b1; busB.signed_mode = sm; busB.in1 = a; busB.in2 = b;
    busC.start = 1'b1; busC.signed_mode = sm; busC.in1 = a; busC.in2 = b;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0; busA.in1 = ~a; busA.in2 = ~b; busA.signed_mode = ~sm;
    busB.start = 1'b0; busB.in1 = ~a; busB.in2 = ~b; busB.signed_mode = ~sm;
    busC.start = 1'b0; busC.in1 = ~a; busC.in2 = ~b; busC.signed_mode = ~sm;
    checkOutput($sformatf("v%0d busyA", id), 32'(busA.busy), 32'd1);
    checkOutput($sformatf("v%0d gelWhileBusyA", id), 32'({busA.g, busA.e, busA.l}), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busA.done) begin
        nA++;
        if (nA == 1) begin
          checkOutput($sformatf("v%0d latA", id), 32'(k), 32'(chunksA));
          checkOutput($sformatf("v%0d gelA", id), 32'({busA.g, busA.e, busA.l}), 32'(gel));
          checkOutput($sformatf("v%0d chunksA", id), 32'(busA.chunks), 32'(chunksA));
          checkOutput($sformatf("v%0d busyEndA", id), 32'(busA.busy), 32'd0);
        end
      end
      if (busB.done) begin
        nB++;
        if (nB == 1) begin
          checkOutput($sformatf("v%0d latB", id), 32'(k), 32'd4);
          checkOutput($sformatf("v%0d gelB", id), 32'({busB.g, busB.e, busB.l}), 32'(gel));
          checkOutput($sformatf("v%0d chunksB", id), 32'(busB.chunks), 32'd4);
        end
      end
      if (busC.done) begin
        nC++;
        if (nC == 1) begin
          checkOutput($sformatf("v%0d latC", id), 32'(k), 32'd1);
          checkOutput($sformatf("v%0d gelC", id), 32'({busC.g, busC.e, busC.l}), 32'(gel));
          checkOutput($sformatf("v%0d chunksC", id), 32'(busC.chunks), 32'd1);
        end
      end
    end
    checkOutput($sformatf("v%0d pulsesA", id), 32'(nA), 32'd1);
    checkOutput($sformatf("v%0d pulsesB", id), 32'(nB), 32'd1);
    checkOutput($sformatf("v%0d pulsesC", id), 32'(nC), 32'd1);
    checkOutput($sformatf("v%0d heldA", id), 32'({busA.g, busA.e, busA.l}), 32'(gel));
    checkOutput($sformatf("v%0d heldB", id), 32'({busB.g, busB.e, busB.l}), 32'(gel));
  endtask

  initial begin
    vec_t vecs[10];
    int   nDone;
    int   lat;

    vecs[0] = '{1'b0, 16'h1234, 16'h1234, EQ, 4};
    vecs[1] = '{1'b0, 16'h8000, 16'h7FFF, GT, 1};
    vecs[2] = '{1'b1, 16'h8000, 16'h7FFF, LT, 1};
    vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, EQ, 4};
    vecs[4] = '{1'b0, 16'h0100, 16'h0200, LT, 2};
    vecs[5] = '{1'b0, 16'h1235, 16'h1234, GT, 4};
    vecs[6] = '{1'b1, 16'hFFFF, 16'h0001, LT, 1};
    vecs[7] = '{1'b1, 16'h0005, 16'hFFFB, GT, 1};
    vecs[8] = '{1'b0, 16'h00A0, 16'h00B0, LT, 3};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, EQ, 4};

    busA.start = 1'b0; busA.signed_mode = 1'b0; busA.in1 = '0; busA.in2 = '0;
    busB.start = 1'b0; busB.signed_mode = 1'b0; busB.in1 = '0; busB.in2 = '0;
    busC.start = 1'b0; busC.signed_mode = 1'b0; busC.in1 = '0; busC.in2 = '0;

    repeat (2) @(negedge clk);
    checkOutput("resetBusyA", 32'(busA.busy), 32'd0);
    checkOutput("resetDoneA", 32'(busA.done), 32'd0);
    checkOutput("resetGelA", 32'({busA.g, busA.e, busA.l}), 32'd0);
    checkOutput("resetChunksA", 32'(busA.chunks), 32'd0);
    checkOutput("resetBusyB", 32'(busB.busy), 32'd0);
    checkOutput("resetBusyC", 32'(busC.busy), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(i, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].gel, vecs[i].chunksA);
    end

    // Start while busy must be ignored: only the first compare completes.
    nDone = 0;
    lat   = 0;
    @(negedge clk);
    busA.start = 1'b1; busA.signed_mode = 1'b0; busA.in1 = 16'h0001; busA.in2 = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b1; busA.in1 = 16'hFFFF; busA.in2 = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busA.done) begin
        nDone++;
        if (nDone == 1) begin
          lat = k;
          checkOutput("busyStartGel", 32'({busA.g, busA.e, busA.l}), 32'(LT));
          checkOutput("busyStartChunks", 32'(busA.chunks), 32'd4);
        end
      end
    end
    checkOutput("busyStartLat", 32'(lat), 32'd4);
    checkOutput("busyStartPulses", 32'(nDone), 32'd1);
    checkOutput("busyStartIdle", 32'(busA.busy), 32'd0);

    // Asynchronous reset clears a held result without a clock edge.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstHeldGel", 32'({busA.g, busA.e, busA.l}), 32'd0);
    checkOutput("rstHeldChunks", 32'(busA.chunks), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    busA.start = 1'b1; busA.in1 = 16'h0001; busA.in2 = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    busA.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("preRstBusy", 32'(busA.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busA.busy), 32'd0);
    checkOutput("midRstDone", 32'(busA.done), 32'd0);
    checkOutput("midRstGel", 32'({busA.g, busA.e, busA.l}), 32'd0);
    checkOutput("midRstChunks", 32'(busA.chunks), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nDone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busA.done || busA.busy) nDone++;
    end
    checkOutput("postRstQuiet", 32'(nDone), 32'd0);

    applyStimulus(10, 1'b0, 16'h0005, 16'h0005, EQ, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
